// File: rtl/ac97_pkg.sv
// Shared constants, state encoding and slot geometry for the AC97 frame timer.
package ac97_pkg;

  localparam int unsigned FRAME_BITS   = 256;
  localparam int unsigned TAG_BITS     = 16;
  localparam int unsigned SLOT_BITS    = 20;
  localparam int unsigned NUM_IN_SLOTS = 5;
  localparam int unsigned CNT_W        = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Last bit position of slot k within the frame (slot 0 is the tag).
  function automatic int unsigned slot_end(input int unsigned k);
    return TAG_BITS + SLOT_BITS * k - 1;
  endfunction

endpackage

// File: rtl/ac97_frame_timer.sv
// AC97 frame timing generator: bit counter, run/drain FSM and registered
// decode of SYNC, slot latch enables, output load strobe and frame start.
module ac97_frame_timer
  import ac97_pkg::*;
#(
  parameter int unsigned LE_DLY   = 2,
  parameter int unsigned SYNC_LEN = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic                    sync,
  output logic [NUM_IN_SLOTS-1:0] out_le,
  output logic                    ld,
  output logic                    frame_start,
  output logic                    busy,
  output logic [CNT_W-1:0]        bit_cnt
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC_LEN);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    sync_q, sync_d;
  logic                    ld_q, ld_d;
  logic                    fs_q, fs_d;
  logic                    busy_q, busy_d;
  logic [NUM_IN_SLOTS-1:0] le_q, le_d;
  logic [NUM_IN_SLOTS-1:0] le_hit;

  // Latch-enable compare points are fixed at elaboration.
  for (genvar k = 0; k < NUM_IN_SLOTS; k++) begin : g_le
    localparam int unsigned LE_POS = slot_end(k) + LE_DLY;
    assign le_hit[k] = (cnt_q == CNT_W'(LE_POS));
  end

  // Next state plus output decode; outputs are registered one cycle after
  // the internal counter, so ld leads the matching frame_start by one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_d      = 1'b0;
    busy_d    = (state_q != ST_IDLE);
    bit_cnt_d = cnt_q;
    sync_d    = busy_d && (cnt_q < SYNC_END);
    fs_d      = busy_d && (cnt_q == '0);
    le_d      = busy_d ? le_hit : '0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = ST_RUN;
          ld_d    = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!en) begin
          state_d = ST_DRAIN;
        end else if (cnt_q == LAST_BIT) begin
          ld_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      sync_q    <= 1'b0;
      ld_q      <= 1'b0;
      fs_q      <= 1'b0;
      busy_q    <= 1'b0;
      le_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sync_q    <= sync_d;
      ld_q      <= ld_d;
      fs_q      <= fs_d;
      busy_q    <= busy_d;
      le_q      <= le_d;
    end
  end

  assign sync        = sync_q;
  assign out_le      = le_q;
  assign ld          = ld_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_ac97_frame_timer.sv
// Directed bench for ac97_frame_timer: default-parameter instance plus a
// LE_DLY=0 / SYNC_LEN=1 instance sharing the same clock, reset and enable.
module tb_ac97_frame_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;

  logic       sync_a, ld_a, fs_a, busy_a;
  logic [4:0] le_a;
  logic [7:0] bc_a;
  logic       sync_b, ld_b, fs_b, busy_b;
  logic [4:0] le_b;
  logic [7:0] bc_b;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ac97_frame_timer #(.LE_DLY(2), .SYNC_LEN(16)) dut_a (
    .clk(clk), .rst(rst), .en(en), .sync(sync_a), .out_le(le_a),
    .ld(ld_a), .frame_start(fs_a), .busy(busy_a), .bit_cnt(bc_a)
  );

  ac97_frame_timer #(.LE_DLY(0), .SYNC_LEN(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .sync(sync_b), .out_le(le_b),
    .ld(ld_b), .frame_start(fs_b), .busy(busy_b), .bit_cnt(bc_b)
  );

  // Packed view: {bit_cnt, busy, sync, frame_start, ld, out_le}
  wire [16:0] obs_a = {bc_a, busy_a, sync_a, fs_a, ld_a, le_a};
  wire [16:0] obs_b = {bc_b, busy_b, sync_b, fs_b, ld_b, le_b};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for a given visible position; alt selects the LE_DLY=0/SYNC_LEN=1 table.
  function automatic logic [16:0] exp_vec(input logic b, input logic [7:0] cnt,
                                          input logic l, input logic alt);
    logic [4:0] le;
    logic       s;
    le = 5'b0;
    if (!alt) begin
      case (cnt)
        8'd17: le = 5'b00001;
        8'd37: le = 5'b00010;
        8'd57: le = 5'b00100;
        8'd77: le = 5'b01000;
        8'd97: le = 5'b10000;
        default: le = 5'b0;
      endcase
      s = b && (cnt < 8'd16);
    end else begin
      case (cnt)
        8'd15: le = 5'b00001;
        8'd35: le = 5'b00010;
        8'd55: le = 5'b00100;
        8'd75: le = 5'b01000;
        8'd95: le = 5'b10000;
        default: le = 5'b0;
      endcase
      s = b && (cnt == 8'd0);
    end
    if (!b) le = 5'b0;
    return {(b ? cnt : 8'd0), b, s, b && (cnt == 8'd0), l, le};
  endfunction

  task automatic start();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    rst = 1'b0;
    en  = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [16:0] exp;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) tick();
    exp = exp_vec(1'b0, 8'd0, 1'b0, 1'b0);
    checks++;
    if (obs_a !== exp) begin
      fails++;
      $display("FAIL reset_hold: got %h want %h", obs_a, exp);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs_a !== exp || obs_b !== exp) begin
        fails++;
        $display("FAIL reset_idle c%0d: got %h/%h want %h", i, obs_a, obs_b, exp);
      end
    end
  endtask

  task automatic test_frame();
    logic [16:0] exp;
    start();
    exp = exp_vec(1'b0, 8'd0, 1'b1, 1'b0);
    checks++;
    if (obs_a !== exp) begin
      fails++;
      $display("FAIL frame_first_ld: got %h want %h", obs_a, exp);
    end
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 256; i++) begin
        tick();
        exp = exp_vec(1'b1, 8'(i), i == 255, 1'b0);
        checks++;
        if (obs_a !== exp) begin
          fails++;
          $display("FAIL frame f%0d b%0d: got %h want %h", f, i, obs_a, exp);
        end
      end
    end
  endtask

  task automatic test_drain();
    logic [16:0] exp;
    start();
    exp = exp_vec(1'b0, 8'd0, 1'b1, 1'b0);
    checks++;
    if (obs_a !== exp) begin
      fails++;
      $display("FAIL drain_first_ld: got %h want %h", obs_a, exp);
    end
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 256; i++) begin
        tick();
        exp = exp_vec(1'b1, 8'(i), (i == 255) && (f < 2), 1'b0);
        checks++;
        if (obs_a !== exp) begin
          fails++;
          $display("FAIL drain f%0d b%0d: got %h want %h", f, i, obs_a, exp);
        end
        if (f == 2 && i == 100) en = 1'b0;
      end
    end
    exp = exp_vec(1'b0, 8'd0, 1'b0, 1'b0);
    for (int j = 0; j < 20; j++) begin
      tick();
      checks++;
      if (obs_a !== exp) begin
        fails++;
        $display("FAIL drain_idle c%0d: got %h want %h", j, obs_a, exp);
      end
    end
  endtask

  task automatic test_drain_ignore_en();
    logic [16:0] exp;
    start();
    exp = exp_vec(1'b0, 8'd0, 1'b1, 1'b0);
    checks++;
    if (obs_a !== exp) begin
      fails++;
      $display("FAIL ign_first_ld: got %h want %h", obs_a, exp);
    end
    for (int i = 0; i < 256; i++) begin
      tick();
      exp = exp_vec(1'b1, 8'(i), 1'b0, 1'b0);
      checks++;
      if (obs_a !== exp) begin
        fails++;
        $display("FAIL ign_frame b%0d: got %h want %h", i, obs_a, exp);
      end
      if (i == 50)  en = 1'b0;
      if (i == 200) en = 1'b1;
      if (i == 201) en = 1'b0;
    end
    exp = exp_vec(1'b0, 8'd0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (obs_a !== exp) begin
        fails++;
        $display("FAIL ign_idle c%0d: got %h want %h", j, obs_a, exp);
      end
    end
    en = 1'b1;
    tick();
    exp = exp_vec(1'b0, 8'd0, 1'b1, 1'b0);
    checks++;
    if (obs_a !== exp) begin
      fails++;
      $display("FAIL ign_restart_ld: got %h want %h", obs_a, exp);
    end
    tick();
    exp = exp_vec(1'b1, 8'd0, 1'b0, 1'b0);
    checks++;
    if (obs_a !== exp) begin
      fails++;
      $display("FAIL ign_restart_fs: got %h want %h", obs_a, exp);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [16:0] exp;
    start();
    for (int i = 0; i < 256 + 51; i++) begin
      tick();
      exp = exp_vec(1'b1, 8'(i % 256), i == 255, 1'b0);
      checks++;
      if (obs_a !== exp) begin
        fails++;
        $display("FAIL rmid_run b%0d: got %h want %h", i, obs_a, exp);
      end
    end
    // en stays high during reset: reset must still win and suppress ld.
    rst = 1'b1;
    tick();
    exp = exp_vec(1'b0, 8'd0, 1'b0, 1'b0);
    checks++;
    if (obs_a !== exp) begin
      fails++;
      $display("FAIL rmid_abort: got %h want %h", obs_a, exp);
    end
    rst = 1'b0;
    en  = 1'b0;
    for (int j = 0; j < 120; j++) begin
      tick();
      checks++;
      if (obs_a !== exp) begin
        fails++;
        $display("FAIL rmid_quiet c%0d: got %h want %h", j, obs_a, exp);
      end
    end
  endtask

  task automatic test_params();
    logic [16:0] exp;
    start();
    exp = exp_vec(1'b0, 8'd0, 1'b1, 1'b1);
    checks++;
    if (obs_b !== exp) begin
      fails++;
      $display("FAIL params_ld: got %h want %h", obs_b, exp);
    end
    for (int i = 0; i < 256; i++) begin
      tick();
      exp = exp_vec(1'b1, 8'(i), i == 255, 1'b1);
      checks++;
      if (obs_b !== exp) begin
        fails++;
        $display("FAIL params b%0d: got %h want %h", i, obs_b, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_frame();
    test_drain();
    test_drain_ignore_en();
    test_reset_mid_frame();
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
